// File: rtl/shift_port.sv
// Full-duplex '595/'165 shift port: one start/busy/done transfer of WIDTH bits, sclk = clk/(2*DIV).
// Latency (2*WIDTH+1)*DIV clk from accepting edge to done; start is ignored while busy (no queueing).
module shift_port #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_tx_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_sclk,
    output logic             o_sdo,
    input  logic             i_sdi,
    output logic             o_latch
);
    localparam int BW = $clog2(WIDTH);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [BW-1:0]    r_bit;
    logic [PW-1:0]    r_phase;

    logic             w_ph_last;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_tx_shift;
    logic [WIDTH-1:0] w_rx_shift;

    assign w_ph_last = (r_phase == PH_LAST);

    // The tx shadow is consumed from the sending end, so the next bit is always adjacent to it.
    assign w_first_bit = MSB_FIRST ? i_tx_data[WIDTH-1] : i_tx_data[0];
    assign w_next_bit  = MSB_FIRST ? r_tx[WIDTH-2]      : r_tx[1];
    assign w_tx_shift  = MSB_FIRST ? (r_tx << 1)        : (r_tx >> 1);
    assign w_rx_shift  = MSB_FIRST ? {r_rx[WIDTH-2:0], i_sdi} : {i_sdi, r_rx[WIDTH-1:1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_bit     <= '0;
            r_phase   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_rx_data <= '0;
            o_sclk    <= 1'b0;
            o_sdo     <= 1'b0;
            o_latch   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_tx    <= i_tx_data;
                        r_bit   <= '0;
                        r_phase <= '0;
                        o_busy  <= 1'b1;
                        o_sdo   <= w_first_bit;
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_ph_last) begin
                        o_sclk  <= 1'b1;
                        r_rx    <= w_rx_shift;
                        r_phase <= '0;
                        r_state <= HIGH;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                HIGH: begin
                    if (w_ph_last) begin
                        o_sclk  <= 1'b0;
                        r_phase <= '0;
                        if (r_bit == BIT_LAST) begin
                            o_sdo   <= 1'b0;
                            o_latch <= 1'b1;
                            r_state <= LATCH;
                        end else begin
                            r_bit   <= r_bit + BW'(1);
                            r_tx    <= w_tx_shift;
                            o_sdo   <= w_next_bit;
                            r_state <= LOW;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                LATCH: begin
                    if (w_ph_last) begin
                        o_latch   <= 1'b0;
                        o_rx_data <= r_rx;
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                        r_phase   <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
